// File: rtl/alien_pkg.sv
// Shared constants and scheduler state encoding for the alien fleet fire logic.
package alien_pkg;

  localparam logic [3:0] GAME_PLAY  = 4'd1;
  localparam int         ALIEN_COLS = 10;
  localparam int         ALIEN_ROWS = 6;
  localparam logic [9:0] COL_PITCH  = 10'd64;
  localparam logic [9:0] ROW_PITCH  = 10'd32;
  localparam logic [9:0] X_CENTER   = 10'd16;
  localparam logic [9:0] Y_BASE     = 10'd64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COOLDOWN,
    ST_WAIT_SLOT,
    ST_SELECT,
    ST_SCAN,
    ST_ISSUE
  } sched_state_t;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded with 8'hA5.
module lfsr8 (
  input  logic       frame_clk,
  input  logic       Reset_n,
  output logic [7:0] lfsr_state
);

  localparam logic [7:0] SEED = 8'hA5;

  logic [7:0] lfsr_reg;
  logic       feedback;

  assign feedback = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) lfsr_reg <= SEED;
    else          lfsr_reg <= {lfsr_reg[6:0], feedback};
  end

  assign lfsr_state = lfsr_reg;

endmodule

// File: rtl/alien_fire_scheduler.sv
// Picks when, from which column and into which missile slot the alien fleet fires,
// alternating aimed and pseudo-random column choices between cooldown periods.
module alien_fire_scheduler
  import alien_pkg::*;
#(
  parameter  int NUM_SLOTS = 4,
  parameter  int COOLDOWN  = 120,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1
) (
  input  logic                                  frame_clk,
  input  logic                                  Reset_n,
  input  logic [3:0]                            game_state,
  input  logic [ALIEN_COLS-1:0][ALIEN_ROWS-1:0] alien_grid,
  input  logic [9:0]                            alien_offset,
  input  logic [9:0]                            alien_y,
  input  logic [9:0]                            ship_x,
  input  logic [NUM_SLOTS-1:0]                  slot_busy,
  input  logic                                  fire_ready,
  output logic                                  fire_valid,
  output logic [SW-1:0]                         fire_slot,
  output logic [9:0]                            fire_x,
  output logic [9:0]                            fire_y,
  output logic [7:0]                            shot_count
);

  sched_state_t  state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    attempts_reg, attempts_next;
  logic [3:0]    col_reg, col_next;
  logic          aim_reg, aim_next;
  logic          fire_valid_reg, fire_valid_next;
  logic [SW-1:0] fire_slot_reg, fire_slot_next;
  logic [9:0]    fire_x_reg, fire_x_next;
  logic [9:0]    fire_y_reg, fire_y_next;
  logic [7:0]    shot_count_reg, shot_count_next;

  logic [7:0]    lfsr_state;
  logic [SW-1:0] free_idx;
  logic          free_any;
  logic [ALIEN_ROWS-1:0] col_bits;
  logic [2:0]    hit_row;
  logic          hit;
  logic [3:0]    aim_col, rand_col;
  logic          unused_bits;

  lfsr8 u_lfsr (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .lfsr_state (lfsr_state)
  );

  assign unused_bits = ^{ship_x[5:0], lfsr_state[7:4]};

  // Lowest-index free slot wins.
  always_comb begin
    free_idx = '0;
    free_any = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        free_idx = SW'(i);
        free_any = 1'b1;
      end
    end
  end

  // Bottom-most alive alien (highest row index) of the column under scan.
  assign col_bits = alien_grid[col_reg];
  always_comb begin
    hit_row = '0;
    hit     = 1'b0;
    for (int r = 0; r < ALIEN_ROWS; r++) begin
      if (col_bits[r]) begin
        hit_row = 3'(r);
        hit     = 1'b1;
      end
    end
  end

  assign aim_col  = (ship_x[9:6] > 4'd9) ? 4'd9 : ship_x[9:6];
  assign rand_col = (lfsr_state[3:0] > 4'd9) ? (lfsr_state[3:0] - 4'd6) : lfsr_state[3:0];

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    attempts_next   = attempts_reg;
    col_next        = col_reg;
    aim_next        = aim_reg;
    fire_slot_next  = fire_slot_reg;
    fire_x_next     = fire_x_reg;
    fire_y_next     = fire_y_reg;
    shot_count_next = shot_count_reg;

    case (state_reg)
      ST_IDLE: begin
        cnt_next      = '0;
        attempts_next = '0;
        aim_next      = 1'b0;
        state_next    = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cnt_reg == CW'(COOLDOWN - 1)) begin
          cnt_next   = '0;
          state_next = ST_WAIT_SLOT;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_WAIT_SLOT: begin
        if (free_any) begin
          fire_slot_next = free_idx;
          state_next     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        col_next      = aim_reg ? rand_col : aim_col;
        attempts_next = '0;
        state_next    = ST_SCAN;
      end
      ST_SCAN: begin
        if (hit) begin
          fire_x_next = 10'(col_reg) * COL_PITCH + alien_offset + X_CENTER;
          fire_y_next = alien_y + Y_BASE + 10'(hit_row) * ROW_PITCH;
          state_next  = ST_ISSUE;
        end else if (attempts_reg == 4'(ALIEN_COLS - 1)) begin
          aim_next   = ~aim_reg;
          state_next = ST_COOLDOWN;
        end else begin
          col_next      = (col_reg == 4'(ALIEN_COLS - 1)) ? 4'd0 : col_reg + 4'd1;
          attempts_next = attempts_reg + 4'd1;
        end
      end
      ST_ISSUE: begin
        if (fire_valid_reg && fire_ready) begin
          shot_count_next = shot_count_reg + 8'd1;
          aim_next        = ~aim_reg;
          state_next      = ST_COOLDOWN;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Leaving play aborts everything, but a transfer on this same edge still counts.
    if (game_state != GAME_PLAY) begin
      state_next     = ST_IDLE;
      cnt_next       = '0;
      attempts_next  = '0;
      aim_next       = 1'b0;
      fire_slot_next = '0;
      fire_x_next    = '0;
      fire_y_next    = '0;
    end

    fire_valid_next = (state_next == ST_ISSUE);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      attempts_reg   <= '0;
      col_reg        <= '0;
      aim_reg        <= 1'b0;
      fire_valid_reg <= 1'b0;
      fire_slot_reg  <= '0;
      fire_x_reg     <= '0;
      fire_y_reg     <= '0;
      shot_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      attempts_reg   <= attempts_next;
      col_reg        <= col_next;
      aim_reg        <= aim_next;
      fire_valid_reg <= fire_valid_next;
      fire_slot_reg  <= fire_slot_next;
      fire_x_reg     <= fire_x_next;
      fire_y_reg     <= fire_y_next;
      shot_count_reg <= shot_count_next;
    end
  end

  assign fire_valid = fire_valid_reg;
  assign fire_slot  = fire_slot_reg;
  assign fire_x     = fire_x_reg;
  assign fire_y     = fire_y_reg;
  assign shot_count = shot_count_reg;

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Self-checking bench: table of fixed scenarios, hand-written corner sequences,
// then randomized attempts checked against a transaction-level model.
module tb_alien_fire_scheduler;
  import alien_pkg::*;

  localparam int NS = 4;
  localparam int CD = 4;

  logic            frame_clk = 1'b0;
  logic            Reset_n;
  logic [3:0]      game_state;
  logic [9:0][5:0] alien_grid;
  logic [9:0]      alien_offset, alien_y, ship_x;
  logic [NS-1:0]   slot_busy;
  logic            fire_ready;
  logic            fire_valid;
  logic [1:0]      fire_slot;
  logic [9:0]      fire_x, fire_y;
  logic [7:0]      shot_count;

  alien_fire_scheduler #(.NUM_SLOTS(NS), .COOLDOWN(CD)) dut (
    .frame_clk    (frame_clk),
    .Reset_n      (Reset_n),
    .game_state   (game_state),
    .alien_grid   (alien_grid),
    .alien_offset (alien_offset),
    .alien_y      (alien_y),
    .ship_x       (ship_x),
    .slot_busy    (slot_busy),
    .fire_ready   (fire_ready),
    .fire_valid   (fire_valid),
    .fire_slot    (fire_slot),
    .fire_x       (fire_x),
    .fire_y       (fire_y),
    .shot_count   (shot_count)
  );

  always #5 frame_clk = ~frame_clk;

  int         checks = 0;
  int         errors = 0;
  int         exp_shots = 0;
  bit         aim_m = 1'b0;
  logic [7:0] lfsr_m;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & 8'hB8)};
  endfunction

  // Reference LFSR value after each edge since reset.
  always @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) lfsr_m <= 8'hA5;
    else          lfsr_m <= lfsr_next(lfsr_m);
  end

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edges until fire_valid is seen high, 0 if never within the budget.
  task automatic await_valid(input int budget, output int seen);
    seen = 0;
    for (int i = 1; i <= budget; i++) begin
      tick;
      if (fire_valid === 1'b1) begin
        seen = i;
        break;
      end
    end
  endtask

  task automatic enter_play;
    game_state = 4'd2;
    tick;
    game_state = GAME_PLAY;
    tick;
    aim_m = 1'b0;
  endtask

  function automatic int start_col(input bit aim, input logic [9:0] sx, input logic [7:0] l);
    int c;
    if (!aim) begin
      c = int'(sx) / 64;
      if (c > 9) c = 9;
    end else begin
      c = int'(l) % 16;
      if (c > 9) c = c - 6;
    end
    return c;
  endfunction

  // Predicts the attempt that starts at the current cooldown entry (0 delay = fleet dead).
  task automatic predict(output int delay, output int ex, output int ey, output int es);
    logic [7:0] l;
    int c0, c, row;
    bit found;
    l = lfsr_m;
    repeat (CD + 1) l = lfsr_next(l);
    c0 = start_col(aim_m, ship_x, l);
    delay = 0; ex = 0; ey = 0; es = 0;
    for (int i = NS - 1; i >= 0; i--) if (!slot_busy[i]) es = i;
    for (int k = 0; k < 10; k++) begin
      c = (c0 + k) % 10;
      if (alien_grid[c] != 6'd0) begin
        found = 1'b0;
        row = 0;
        for (int r = 5; r >= 0; r--) begin
          if (!found && alien_grid[c][r]) begin
            row = r;
            found = 1'b1;
          end
        end
        delay = CD + 3 + k;
        ex = (c * 64 + int'(alien_offset) + 16) % 1024;
        ey = (int'(alien_y) + 64 + 32 * row) % 1024;
        break;
      end
    end
  endtask

  task automatic handshake(input int ex, input int ey, input int es);
    bit stable = 1'b1;
    for (int w = 0; w < 12; w++) begin
      fire_ready = (w >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      tick;
      if (fire_ready) break;
      if (fire_valid !== 1'b1 || fire_x !== 10'(ex) || fire_y !== 10'(ey) || fire_slot !== 2'(es))
        stable = 1'b0;
    end
    fire_ready = 1'b0;
    exp_shots = (exp_shots + 1) % 256;
    aim_m = ~aim_m;
    check("hold_stable", 32'(stable), 32'd1);
    check("valid_drop", 32'(fire_valid), 32'd0);
    check("shot_count", 32'(shot_count), 32'(exp_shots));
    $display("shot %0d: slot=%0d x=%0d y=%0d", exp_shots, es, ex, ey);
  endtask

  typedef struct {
    logic [9:0][5:0] grid;
    logic [9:0]      sx, off, ay;
    logic [3:0]      busy;
    int              delay, slot, x, y;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [9:0][5:0] g;
    int seen, d, ex, ey, es, mode;
    logic [3:0] b;

    g = '1;
    vecs[0] = '{g, 10'd200, 10'd0, 10'd0, 4'b0000, 7, 0, 208, 224};
    vecs[1] = '{g, 10'd200, 10'd0, 10'd0, 4'b1011, 7, 2, 208, 224};
    g = '0; g[7] = 6'b000100;
    vecs[2] = '{g, 10'd192, 10'd0, 10'd0, 4'b0000, 11, 0, 464, 128};
    g = '0; g[9] = 6'b000011;
    vecs[3] = '{g, 10'd1000, 10'd100, 10'd20, 4'b0001, 7, 1, 692, 116};
    g = '0; g[1] = 6'b100000;
    vecs[4] = '{g, 10'd512, 10'd1000, 10'd900, 4'b0111, 10, 3, 56, 100};

    Reset_n = 1'b0; game_state = 4'd0; alien_grid = '0; alien_offset = '0;
    alien_y = '0; ship_x = '0; slot_busy = '0; fire_ready = 1'b0;
    #22;
    check("rst_valid", 32'(fire_valid), 0);
    check("rst_slot", 32'(fire_slot), 0);
    check("rst_x", 32'(fire_x), 0);
    check("rst_y", 32'(fire_y), 0);
    check("rst_shots", 32'(shot_count), 0);
    Reset_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      alien_grid = vecs[v].grid; ship_x = vecs[v].sx; alien_offset = vecs[v].off;
      alien_y = vecs[v].ay; slot_busy = vecs[v].busy;
      enter_play;
      await_valid(CD + 20, seen);
      check("vec_delay", 32'(seen), 32'(vecs[v].delay));
      check("vec_slot", 32'(fire_slot), 32'(vecs[v].slot));
      check("vec_x", 32'(fire_x), 32'(vecs[v].x));
      check("vec_y", 32'(fire_y), 32'(vecs[v].y));
      handshake(vecs[v].x, vecs[v].y, vecs[v].slot);
    end

    // Dead fleet: full scan with no shot, then the next attempt uses a random column.
    alien_grid = '0; ship_x = 10'd200; alien_offset = '0; alien_y = '0; slot_busy = '0;
    enter_play;
    await_valid(CD + 12, seen);
    check("dead_no_valid", 32'(seen), 0);
    check("dead_shots", 32'(shot_count), 32'(exp_shots));
    aim_m = 1'b1;
    alien_grid = '1;
    predict(d, ex, ey, es);
    await_valid(CD + 20, seen);
    check("rand_delay", 32'(seen), 32'(d));
    check("rand_x", 32'(fire_x), 32'(ex));
    handshake(ex, ey, es);

    // All slots busy: hold in WAIT_SLOT until slot 1 frees.
    slot_busy = 4'b1111;
    enter_play;
    await_valid(CD + 8, seen);
    check("busy_hold", 32'(seen), 0);
    slot_busy = 4'b1101;
    await_valid(6, seen);
    check("busy_release", 32'(seen), 3);
    check("busy_slot", 32'(fire_slot), 1);
    handshake(208, 224, 1);

    // fire_ready low for 5 frames, then exactly one transfer.
    slot_busy = '0;
    enter_play;
    await_valid(CD + 20, seen);
    check("stall_delay", 32'(seen), 7);
    begin
      bit stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick;
        if (fire_valid !== 1'b1 || fire_x !== 10'd208 || fire_y !== 10'd224 || fire_slot !== 2'd0)
          stable = 1'b0;
      end
      check("stall_stable", 32'(stable), 1);
    end
    fire_ready = 1'b1;
    tick;
    fire_ready = 1'b0;
    exp_shots++;
    check("stall_xfer", 32'(shot_count), 32'(exp_shots));
    tick; tick;
    check("stall_single", 32'(shot_count), 32'(exp_shots));

    // Leaving play during ISSUE without ready drops the command.
    enter_play;
    await_valid(CD + 20, seen);
    game_state = 4'd2;
    tick;
    check("drop_valid", 32'(fire_valid), 0);
    check("drop_shots", 32'(shot_count), 32'(exp_shots));
    check("drop_xy", 32'({fire_x, fire_y, fire_slot}), 0);

    // Transfer and leaving play on the same edge: the shot counts.
    enter_play;
    await_valid(CD + 20, seen);
    fire_ready = 1'b1; game_state = 4'd2;
    tick;
    fire_ready = 1'b0;
    exp_shots++;
    check("leave_xfer", 32'(shot_count), 32'(exp_shots));
    check("leave_valid", 32'(fire_valid), 0);

    // Asynchronous reset mid-handshake, then mid-cooldown.
    enter_play;
    await_valid(CD + 20, seen);
    #3 Reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(fire_valid), 0);
    check("arst_shots", 32'(shot_count), 0);
    exp_shots = 0;
    #2 Reset_n = 1'b1;
    enter_play;
    tick; tick;
    #2 Reset_n = 1'b0;
    #2 Reset_n = 1'b1;
    check("arst2_out", 32'({fire_valid, fire_x, fire_y, fire_slot, shot_count}), 0);
    enter_play;
    predict(d, ex, ey, es);
    await_valid(CD + 20, seen);
    check("arst2_delay", 32'(seen), 32'(d));
    handshake(ex, ey, es);

    // Randomized attempts against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 7);
      if (mode == 0) alien_grid = '0;
      else if (mode == 1) begin
        int c, r;
        c = $urandom_range(0, 9);
        r = $urandom_range(0, 5);
        alien_grid = '0;
        alien_grid[c][r] = 1'b1;
      end else begin
        for (int c = 0; c < 10; c++) alien_grid[c] = 6'($urandom) & 6'($urandom);
      end
      b = 4'($urandom);
      if (b == 4'hF) b[$urandom_range(0, 3)] = 1'b0;
      slot_busy = b;
      ship_x = 10'($urandom); alien_offset = 10'($urandom); alien_y = 10'($urandom);
      predict(d, ex, ey, es);
      if (d == 0) begin
        await_valid(CD + 12, seen);
        check("rnd_dead", 32'(seen), 0);
        check("rnd_dead_shots", 32'(shot_count), 32'(exp_shots));
        aim_m = ~aim_m;
        $display("attempt %0d: fleet empty, no shot", n);
      end else begin
        await_valid(CD + 20, seen);
        check("rnd_delay", 32'(seen), 32'(d));
        check("rnd_slot", 32'(fire_slot), 32'(es));
        check("rnd_x", 32'(fire_x), 32'(ex));
        check("rnd_y", 32'(fire_y), 32'(ey));
        handshake(ex, ey, es);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
